conv_block_addr_ctrl: RTL and testbench
=======================================

# conv_block_addr_ctrl

Parametrised address/sequence controller for the 2D convolution datapath. It drives the shared line-memory addresses and the convolver valid, and it sequences one image column-block at a time through three phases: load, process and unload-while-loading-next. Unlike the single-block controller, it iterates over a programmable number of column blocks and exposes pipeline latency and kernel size as parameters. It also flags unsupported geometry and reports completion. It sits between the host/AXI-lite strobe logic and the memory + convolver array.

## Interface
- NB_ADDRESS, 10, memory address width; must be >= NB_IMAGE
- NB_IMAGE, 10, image height field width
- NB_BLOCK, 4, block count/index width
- LATENCY, 6, cycles from first read address to first convolver result
- KERNEL, 3, kernel height; rows produced per block = H-KERNEL+1

Ports:
- i_CLK  in  1  clock
- i_reset  in  1  reset: synchronous, active-high; clock i_CLK
- i_imgLength  in  NB_IMAGE  image height H, sampled only while i_reset=1
- i_nBlocks  in  NB_BLOCK  column-block count B, sampled only while i_reset=1
- i_SoP  in  1  start-of-process request
- i_valid  in  1  host load/read strobe; rising edges counted
- o_readAdd  out  NB_ADDRESS  memory read address
- o_writeAdd  out  NB_ADDRESS  memory write address
- o_fsm2convVld  out  1  convolver valid
- o_changeBlock  out  1  one-cycle pulse at end of a load or unload phase
- o_EoP  out  1  high throughout UNLOAD
- o_blockIdx  out  NB_BLOCK  current block index
- o_done  out  1  sticky; all blocks finished
- o_err  out  1  sticky; unsupported geometry
- o_state  out  3  state code, for debug

## Operation
- States: LOAD=0, WAIT=1, PROC=2, UNLOAD=3, DONE=4, ERR=5.
- Reset:
  - H <= i_imgLength, B <= i_nBlocks.
  - err <= (H < KERNEL) | (H < LATENCY+1) | (B == 0).
  - state <= err ? ERR : LOAD.
  - All counters, o_blockIdx, o_EoP, o_changeBlock, o_fsm2convVld and o_done <= 0.
- Edge detect:
  - valid_prev <= i_valid every cycle, including during reset.
  - edge = i_valid & ~valid_prev.
- Counters: cnt, rdCnt, wrCnt, each NB_ADDRESS wide.
- Address muxing:
  - In PROC: o_readAdd = rdCnt and o_writeAdd = wrCnt.
  - In all other states: both outputs = cnt.
- LOAD:
  - Each edge: cnt++.
  - Edge with cnt==H-1: cnt <= 0, state <= WAIT, o_changeBlock pulses.
- WAIT:
  - i_SoP=1: state <= PROC, rdCnt <= 0, wrCnt <= 0, o_fsm2convVld <= 1.
  - i_valid is ignored.
- PROC:
  - rdCnt increments each cycle and saturates at H-1.
  - A phase counter k (k=0 on the first PROC cycle) governs wrCnt: wrCnt increments each cycle with k >= LATENCY, so wrCnt = max(0, k-LATENCY).
  - On the cycle with wrCnt==H-KERNEL, the next edge gives: state <= UNLOAD, o_EoP <= 1, o_fsm2convVld <= 0, cnt <= 0.
  - i_valid and i_SoP are ignored.
- UNLOAD:
  - Each edge reads one result and writes the next block's input row at cnt, then cnt++.
  - Edge with cnt==H-1:
    - o_changeBlock pulses, o_EoP <= 0, cnt <= 0.
    - If o_blockIdx==B-1: state <= DONE and o_done <= 1.
    - Otherwise: o_blockIdx++ and state <= WAIT.
- DONE and ERR: absorbing until reset. All inputs are ignored. Addresses hold 0 in ERR and hold last values in DONE.
- Comparisons use H extended to NB_IMAGE+1 bits. H-KERNEL never underflows because err guards it.

## Timing
- Outputs are registered except the address muxes, which are combinational from state and counters.
- The address for a strobe is valid in the same cycle as its edge; the increment is visible the next cycle.
- o_changeBlock is high exactly one cycle, the cycle after the terminal edge. It coincides with the first cycle of WAIT or DONE.
- o_fsm2convVld rises in the first PROC cycle and falls in the first UNLOAD cycle.
- PROC lasts exactly LATENCY+H-KERNEL+1 cycles.
- Holding i_valid high counts once; i_valid must return low before the next strobe.
- i_SoP held high across the WAIT→PROC edge has no further effect.
- Reset mid-phase, in any state, wins: next cycle matches post-reset values and new H/B are sampled.

## Test plan
- Reset with H=10, B=2, LATENCY=6, KERNEL=3 -> o_state=0, all other outputs 0, o_err=0.
- LOAD: 10 one-high/one-low strobes -> o_writeAdd steps 0..9; o_changeBlock is 1 for one cycle after the 10th strobe; o_state=1. A strobe held high 5 cycles advances cnt once.
- i_SoP in WAIT -> o_fsm2convVld=1 next cycle; o_readAdd 0..9 then holds 9; o_writeAdd=0 for k=0..6, then 1..7; PROC lasts 14 cycles; then o_EoP=1, o_fsm2convVld=0, o_state=3.
- UNLOAD: 10 strobes -> o_changeBlock pulse, o_blockIdx=1, o_state=1. Second SoP/PROC/UNLOAD -> o_done=1, o_state=4. Further SoP/strobes leave all outputs unchanged.
- Reset with H=5 (or B=0) -> o_err=1, o_state=5; SoP and strobes ignored. Reset with H=10 clears o_err.
- Reset asserted at PROC cycle 8 -> next cycle all counters 0, o_fsm2convVld=0, o_state=0. i_SoP during LOAD is ignored; cnt is unchanged.

Source files
------------

// File: rtl/conv_block_addr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_block_addr_ctrl_if
// Description : Host/controller bundle for the column-block address controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_block_addr_ctrl_if #(
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10,
  parameter int NB_BLOCK   = 4
);
  logic [NB_IMAGE-1:0]   i_imgLength;
  logic [NB_BLOCK-1:0]   i_nBlocks;
  logic                  i_SoP;
  logic                  i_valid;
  logic [NB_ADDRESS-1:0] o_readAdd;
  logic [NB_ADDRESS-1:0] o_writeAdd;
  logic                  o_fsm2convVld;
  logic                  o_changeBlock;
  logic                  o_EoP;
  logic [NB_BLOCK-1:0]   o_blockIdx;
  logic                  o_done;
  logic                  o_err;
  logic [2:0]            o_state;

  modport master (
    output i_imgLength, i_nBlocks, i_SoP, i_valid,
    input  o_readAdd, o_writeAdd, o_fsm2convVld, o_changeBlock, o_EoP,
           o_blockIdx, o_done, o_err, o_state
  );

  modport slave (
    input  i_imgLength, i_nBlocks, i_SoP, i_valid,
    output o_readAdd, o_writeAdd, o_fsm2convVld, o_changeBlock, o_EoP,
           o_blockIdx, o_done, o_err, o_state
  );
endinterface
`default_nettype wire

// File: rtl/conv_block_addr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_block_addr_ctrl
// Description : Load / process / unload sequencer over B column blocks of
//               height H for the line-memory + convolver datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_block_addr_ctrl #(
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10,
  parameter int NB_BLOCK   = 4,
  parameter int LATENCY    = 6,
  parameter int KERNEL     = 3
) (
  input  wire logic             i_CLK,
  input  wire logic             i_reset,
  conv_block_addr_ctrl_if.slave bus
);

  localparam logic [31:0] c_latency = 32'(LATENCY);
  localparam logic [31:0] c_kernel  = 32'(KERNEL);

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_PROC   = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [NB_IMAGE-1:0]   h_q;
  logic [NB_BLOCK-1:0]   b_q;
  logic [NB_BLOCK-1:0]   blk_q, blk_d;
  logic [NB_ADDRESS-1:0] cnt_q, cnt_d;
  logic [NB_ADDRESS-1:0] rd_q, rd_d;
  logic [NB_ADDRESS-1:0] wr_q, wr_d;
  logic [31:0]           k_q, k_d;
  logic                  valid_prev_q;
  logic                  vld_q, vld_d;
  logic                  chg_q, chg_d;
  logic                  eop_q, eop_d;
  logic                  done_q, done_d;
  logic                  err_q;

  logic                  w_edge;
  logic                  w_err_rst;
  logic [NB_ADDRESS-1:0] w_h_m1;
  logic [31:0]           w_k_last;

  assign w_edge    = bus.i_valid & ~valid_prev_q;
  assign w_err_rst = (32'(bus.i_imgLength) < c_kernel) |
                     (32'(bus.i_imgLength) < c_latency + 32'd1) |
                     (bus.i_nBlocks == '0);
  assign w_h_m1    = NB_ADDRESS'(h_q) - NB_ADDRESS'(1);
  // Last PROC phase index: write pointer reaches H-KERNEL after LATENCY idle cycles.
  assign w_k_last  = 32'(h_q) + c_latency - c_kernel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    k_d     = k_q;
    blk_d   = blk_q;
    vld_d   = vld_q;
    chg_d   = 1'b0;
    eop_d   = eop_q;
    done_d  = done_q;
    case (state_q)
      ST_LOAD: begin
        if (w_edge) begin
          if (cnt_q == w_h_m1) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
            chg_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + NB_ADDRESS'(1);
          end
        end
      end
      ST_WAIT: begin
        if (bus.i_SoP) begin
          state_d = ST_PROC;
          rd_d    = '0;
          wr_d    = '0;
          k_d     = '0;
          vld_d   = 1'b1;
        end
      end
      ST_PROC: begin
        if (k_q == w_k_last) begin
          state_d = ST_UNLOAD;
          eop_d   = 1'b1;
          vld_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          k_d = k_q + 32'd1;
          if (rd_q != w_h_m1) rd_d = rd_q + NB_ADDRESS'(1);
          if (k_q >= c_latency) wr_d = wr_q + NB_ADDRESS'(1);
        end
      end
      ST_UNLOAD: begin
        if (w_edge) begin
          if (cnt_q == w_h_m1) begin
            chg_d = 1'b1;
            eop_d = 1'b0;
            cnt_d = '0;
            if (blk_q == b_q - NB_BLOCK'(1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              blk_d   = blk_q + NB_BLOCK'(1);
              state_d = ST_WAIT;
            end
          end else begin
            cnt_d = cnt_q + NB_ADDRESS'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    valid_prev_q <= bus.i_valid;
    if (i_reset) begin
      h_q     <= bus.i_imgLength;
      b_q     <= bus.i_nBlocks;
      err_q   <= w_err_rst;
      state_q <= w_err_rst ? ST_ERR : ST_LOAD;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      k_q     <= '0;
      blk_q   <= '0;
      vld_q   <= 1'b0;
      chg_q   <= 1'b0;
      eop_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      k_q     <= k_d;
      blk_q   <= blk_d;
      vld_q   <= vld_d;
      chg_q   <= chg_d;
      eop_q   <= eop_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_readAdd     = (state_q == ST_PROC) ? rd_q : cnt_q;
  assign bus.o_writeAdd    = (state_q == ST_PROC) ? wr_q : cnt_q;
  assign bus.o_fsm2convVld = vld_q;
  assign bus.o_changeBlock = chg_q;
  assign bus.o_EoP         = eop_q;
  assign bus.o_blockIdx    = blk_q;
  assign bus.o_done        = done_q;
  assign bus.o_err         = err_q;
  assign bus.o_state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_block_addr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_block_addr_ctrl
// Description : Randomized bench for conv_block_addr_ctrl with a phase-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_block_addr_ctrl;
  localparam int NB_ADDRESS = 10;
  localparam int NB_IMAGE   = 10;
  localparam int NB_BLOCK   = 4;
  localparam int LATENCY    = 6;
  localparam int KERNEL     = 3;

  logic i_CLK   = 1'b0;
  logic i_reset = 1'b1;

  conv_block_addr_ctrl_if #(.NB_ADDRESS(NB_ADDRESS), .NB_IMAGE(NB_IMAGE), .NB_BLOCK(NB_BLOCK)) bus ();

  conv_block_addr_ctrl #(
    .NB_ADDRESS(NB_ADDRESS), .NB_IMAGE(NB_IMAGE), .NB_BLOCK(NB_BLOCK),
    .LATENCY(LATENCY), .KERNEL(KERNEL)
  ) dut (
    .i_CLK  (i_CLK),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 i_CLK = ~i_CLK;

  int n_checks = 0;
  int n_errs   = 0;
  int h, b, blk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_CLK);
      #1;
    end
  endtask

  task automatic chk_idle(input string tag, input int st, input bit err, input bit done,
                          input int bidx, input bit eop);
    chk_eq({tag, "_state"}, 32'(bus.o_state), st);
    chk_eq({tag, "_err"},   32'(bus.o_err), 32'(err));
    chk_eq({tag, "_done"},  32'(bus.o_done), 32'(done));
    chk_eq({tag, "_vld"},   32'(bus.o_fsm2convVld), 0);
    chk_eq({tag, "_chg"},   32'(bus.o_changeBlock), 0);
    chk_eq({tag, "_eop"},   32'(bus.o_EoP), 32'(eop));
    chk_eq({tag, "_blk"},   32'(bus.o_blockIdx), bidx);
    chk_eq({tag, "_radd"},  32'(bus.o_readAdd), 0);
    chk_eq({tag, "_wadd"},  32'(bus.o_writeAdd), 0);
  endtask

  task automatic do_reset(input int hh, input int bb);
    bit exp_err;
    h = hh; b = bb; blk = 0;
    exp_err = (hh < KERNEL) || (hh < LATENCY + 1) || (bb == 0);
    bus.i_imgLength = NB_IMAGE'(hh);
    bus.i_nBlocks   = NB_BLOCK'(bb);
    bus.i_valid     = 1'b0;
    bus.i_SoP       = 1'b0;
    i_reset         = 1'b1;
    tick(1 + int'($urandom_range(0, 1)));
    i_reset = 1'b0;
    chk_idle("rst", exp_err ? 5 : 0, exp_err, 1'b0, 0, 1'b0);
  endtask

  // One host strobe: address must be presented in the edge cycle, held-high counts once.
  task automatic strobe(input string tag, input int exp_addr, input bit last, input bit noise);
    int hold = $urandom_range(1, 5);
    int gap  = $urandom_range(1, 2);
    bus.i_valid = 1'b1;
    chk_eq({tag, "_wadd"}, 32'(bus.o_writeAdd), exp_addr);
    chk_eq({tag, "_radd"}, 32'(bus.o_readAdd), exp_addr);
    tick();
    chk_eq({tag, "_chg_pulse"}, 32'(bus.o_changeBlock), 32'(last));
    for (int t = 1; t < hold + gap; t++) begin
      if (t >= hold) begin
        bus.i_valid = 1'b0;
        bus.i_SoP   = noise & $urandom_range(0, 1) == 1;
      end
      tick();
      if (t == 1) chk_eq({tag, "_chg_once"}, 32'(bus.o_changeBlock), 0);
    end
    bus.i_valid = 1'b0;
    bus.i_SoP   = 1'b0;
  endtask

  task automatic load_phase();
    for (int i = 0; i < h; i++) strobe("load", i, i == h - 1, i < h - 2);
    chk_idle("load_end", 1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic wait_phase();
    int n = $urandom_range(0, 3);
    repeat (n) begin
      bus.i_valid = $urandom_range(0, 1) == 1;
      tick();
      chk_eq("wait_state", 32'(bus.o_state), 1);
    end
    bus.i_valid = 1'b0;
    tick();
    chk_idle("wait", 1, 1'b0, 1'b0, blk, 1'b0);
  endtask

  task automatic proc_phase(input int abort_k);
    int p = LATENCY + h - KERNEL + 1;
    bus.i_SoP = 1'b1;
    tick();
    for (int k = 0; k < p; k++) begin
      if (k == abort_k) begin
        bus.i_valid = 1'b0;
        bus.i_SoP   = 1'b0;
        i_reset     = 1'b1;
        tick();
        i_reset = 1'b0;
        blk = 0;
        chk_idle("abort", 0, 1'b0, 1'b0, 0, 1'b0);
        return;
      end
      chk_eq("proc_state", 32'(bus.o_state), 2);
      chk_eq("proc_vld",   32'(bus.o_fsm2convVld), 1);
      chk_eq("proc_eop",   32'(bus.o_EoP), 0);
      chk_eq("proc_radd",  32'(bus.o_readAdd), (k < h - 1) ? k : h - 1);
      chk_eq("proc_wadd",  32'(bus.o_writeAdd), (k > LATENCY) ? k - LATENCY : 0);
      bus.i_SoP   = (k < 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
      bus.i_valid = (k < p - 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
      tick();
    end
    bus.i_SoP = 1'b0;
    chk_idle("unload_start", 3, 1'b0, 1'b0, blk, 1'b1);
  endtask

  task automatic unload_phase();
    for (int i = 0; i < h; i++) begin
      chk_eq("unload_eop", 32'(bus.o_EoP), 1);
      strobe("unload", i, i == h - 1, 1'b0);
    end
    if (blk == b - 1) begin
      chk_idle("done", 4, 1'b0, 1'b1, blk, 1'b0);
    end else begin
      blk++;
      chk_idle("next_blk", 1, 1'b0, 1'b0, blk, 1'b0);
    end
  endtask

  task automatic absorb_check(input string tag, input int st, input bit err, input bit done,
                              input int bidx);
    repeat (6) begin
      bus.i_SoP   = $urandom_range(0, 1) == 1;
      bus.i_valid = $urandom_range(0, 1) == 1;
      tick();
      chk_idle(tag, st, err, done, bidx, 1'b0);
    end
    bus.i_SoP   = 1'b0;
    bus.i_valid = 1'b0;
  endtask

  task automatic run_job();
    load_phase();
    for (int j = 0; j < b; j++) begin
      wait_phase();
      proc_phase(-1);
      unload_phase();
    end
    absorb_check("done_hold", 4, 1'b0, 1'b1, b - 1);
  endtask

  initial begin
    bus.i_imgLength = '0;
    bus.i_nBlocks   = '0;
    bus.i_SoP       = 1'b0;
    bus.i_valid     = 1'b0;

    do_reset(10, 2);
    run_job();

    repeat (3) begin
      do_reset($urandom_range(7, 20), $urandom_range(1, 3));
      run_job();
    end

    do_reset(10, 1);
    load_phase();
    wait_phase();
    proc_phase(8);
    run_job();

    do_reset(5, 2);
    absorb_check("err_h5", 5, 1'b1, 1'b0, 0);
    do_reset(10, 0);
    absorb_check("err_b0", 5, 1'b1, 1'b0, 0);
    do_reset(6, 1);
    absorb_check("err_h6", 5, 1'b1, 1'b0, 0);
    do_reset(7, 1);
    run_job();
    do_reset(10, 2);
    run_job();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
